// File: rtl/iir_pkg.sv
// Shared types and constants for the multi-channel biquad.
package iir_pkg;

  // Sequencer states: IDLE waits for a sample, then M0..M4 each add one tap.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    M4   = 3'd5
  } state_t;

  // Coefficient bank indices, also used as coef_addr values.
  localparam logic [2:0] CB0 = 3'd0;
  localparam logic [2:0] CB1 = 3'd1;
  localparam logic [2:0] CB2 = 3'd2;
  localparam logic [2:0] CA1 = 3'd3;
  localparam logic [2:0] CA2 = 3'd4;

  // Float word width: sign + exponent + mantissa.
  function automatic int float_width(input int man_w, input int exp_w);
    return man_w + exp_w + 1;
  endfunction

endpackage

// File: rtl/iir_hist_mem.sv
// Per-channel filter history: x[n-1], x[n-2], y[n-1], y[n-2].
module iir_hist_mem #(
  parameter int W   = 32,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CHW-1:0] ch,
  input  logic           we,
  input  logic [W-1:0]   x_new,
  input  logic [W-1:0]   y_new,
  output logic [W-1:0]   x1,
  output logic [W-1:0]   x2,
  output logic [W-1:0]   y1,
  output logic [W-1:0]   y2
);

  logic [W-1:0] x1_m [NCH];
  logic [W-1:0] x2_m [NCH];
  logic [W-1:0] y1_m [NCH];
  logic [W-1:0] y2_m [NCH];

  assign x1 = x1_m[ch];
  assign x2 = x2_m[ch];
  assign y1 = y1_m[ch];
  assign y2 = y2_m[ch];

  // Clear every channel on reset; shift the selected channel's delay line on commit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so x2 takes the old x1 in the same edge x1 is updated.
    if (rst) begin
      // NOTE: history is architectural state (a stale entry changes every later output), so it is reset despite being an array.
      for (int i = 0; i < NCH; i++) begin
        x1_m[i] <= '0;
        x2_m[i] <= '0;
        y1_m[i] <= '0;
        y2_m[i] <= '0;
      end
    end else if (we) begin
      x2_m[ch] <= x1_m[ch];
      x1_m[ch] <= x_new;
      y2_m[ch] <= y1_m[ch];
      y1_m[ch] <= y_new;
    end
  end

endmodule

// File: rtl/int2float.sv
// Signed MAN-bit integer to float. Exact for every input since |x| < 2^MAN.
module int2float #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic signed [MAN-1:0]   x,
  output logic        [MAN+EXP:0] f
);

  localparam int BIAS = (1 << (EXP - 1)) - 1;

  logic [MAN-1:0] mag;
  logic [MAN-1:0] norm;
  int             pos;
  logic           unused_bits;

  // Magnitude, leading-one search and normalisation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    f    = '0;
    pos  = 0;
    mag  = x[MAN-1] ? -x : x;
    for (int i = 0; i < MAN; i++) begin
      if (mag[i]) pos = i;
    end
    norm = mag << (MAN - 1 - pos);
    if (mag != '0) begin
      f[MAN+EXP]     = x[MAN-1];
      f[MAN+EXP-1:MAN] = EXP'(BIAS + pos);
      f[MAN-1:0]     = {norm[MAN-2:0], 1'b0};
    end
  end

  // The leading one is implicit in the float format.
  assign unused_bits = norm[MAN-1];

endmodule

// File: rtl/mult.sv
// Float multiplier: truncating, zero/denormal inputs give +0, overflow saturates to inf.
module mult #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN+EXP:0] a,
  input  logic [MAN+EXP:0] b,
  output logic [MAN+EXP:0] y
);

  localparam int W  = MAN + EXP + 1;
  localparam int EW = EXP + 2;
  localparam logic signed [EW-1:0] BIAS_E = EW'((1 << (EXP - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP) - 1);

  logic [MAN:0]          ma, mb;
  logic [2*MAN+1:0]      prod;
  logic [MAN-1:0]        frac;
  logic                  sgn;
  logic signed [EW-1:0]  e_n;
  logic                  unused_bits;

  // Mantissa product, one-bit normalisation, range clamp.
  always_comb begin
    ma   = {1'b1, a[MAN-1:0]};
    mb   = {1'b1, b[MAN-1:0]};
    prod = {{(MAN+1){1'b0}}, ma} * {{(MAN+1){1'b0}}, mb};
    sgn  = a[W-1] ^ b[W-1];
    e_n  = $signed({2'b00, a[W-2:MAN]}) + $signed({2'b00, b[W-2:MAN]}) - BIAS_E;
    frac = prod[2*MAN-1 -: MAN];
    if (prod[2*MAN+1]) begin
      frac = prod[2*MAN -: MAN];
      e_n  = e_n + 1;
    end
    y = {sgn, e_n[EXP-1:0], frac};
    if (a[W-2:MAN] == '0 || b[W-2:MAN] == '0 || e_n <= 0) begin
      y = '0;
    end else if (e_n >= EMAX_E) begin
      y = {sgn, {EXP{1'b1}}, {MAN{1'b0}}};
    end
  end

  // Bits below the kept mantissa are truncated.
  assign unused_bits = ^prod[MAN-1:0];

endmodule

// File: rtl/soma.sv
// Float adder: align, add/subtract magnitudes, renormalise, truncate.
module soma #(
  parameter int MAN = 23,
  parameter int EXP = 8
) (
  input  logic [MAN+EXP:0] a,
  input  logic [MAN+EXP:0] b,
  output logic [MAN+EXP:0] y
);

  localparam int W  = MAN + EXP + 1;
  localparam int GW = 3;
  localparam int SW = MAN + 1 + GW;
  localparam int EW = EXP + 2;
  localparam logic [EXP-1:0]        SW_E   = EXP'(SW);
  localparam logic signed [EW-1:0]  EMAX_E = EW'((1 << EXP) - 1);

  logic [W-1:0]          big, sml;
  logic [EXP-1:0]        d;
  logic [SW-1:0]         mb, ms;
  logic [SW:0]           sum;
  logic [SW-1:0]         norm;
  logic signed [EW-1:0]  e_n;
  int                    p;
  logic                  unused_bits;

  // Order by magnitude so the result takes the larger operand's sign.
  always_comb begin
    big  = a;
    sml  = b;
    p    = 0;
    norm = '0;
    if (b[W-2:0] > a[W-2:0]) begin
      big = b;
      sml = a;
    end
    d   = big[W-2:MAN] - sml[W-2:MAN];
    mb  = {1'b1, big[MAN-1:0], {GW{1'b0}}};
    ms  = (d >= SW_E) ? '0 : ({1'b1, sml[MAN-1:0], {GW{1'b0}}} >> d);
    if (big[W-1] ^ sml[W-1]) sum = {1'b0, mb} - {1'b0, ms};
    else                     sum = {1'b0, mb} + {1'b0, ms};
    e_n = $signed({2'b00, big[W-2:MAN]});
    if (sum[SW]) begin
      norm = sum[SW:1];
      e_n  = e_n + 1;
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (sum[i]) p = i;
      end
      norm = sum[SW-1:0] << (SW - 1 - p);
      e_n  = e_n - EW'(SW - 1 - p);
    end
    if (b[W-2:MAN] == '0) begin
      y = a;
    end else if (a[W-2:MAN] == '0) begin
      y = b;
    end else if (sum == '0 || e_n <= 0) begin
      y = '0;
    end else if (e_n >= EMAX_E) begin
      y = {big[W-1], {EXP{1'b1}}, {MAN{1'b0}}};
    end else begin
      y = {big[W-1], e_n[EXP-1:0], norm[SW-2 -: MAN]};
    end
  end

  // Implicit leading one and truncated guard bits.
  assign unused_bits = ^{norm[SW-1], norm[GW-1:0]};

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel float biquad: one multiplier and one adder,
// five accumulate steps per sample, runtime-loadable coefficients.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int MAN = 23,
  parameter int EXP = 8,
  parameter int NCH = 4,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1,
  parameter logic [MAN+EXP:0] B0 = 32'h3F800000,
  parameter logic [MAN+EXP:0] B1 = 32'h00000000,
  parameter logic [MAN+EXP:0] B2 = 32'h00000000,
  parameter logic [MAN+EXP:0] A1 = 32'h00000000,
  parameter logic [MAN+EXP:0] A2 = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CHW-1:0]        in_ch,
  input  logic signed [MAN-1:0] x,
  input  logic                  coef_we,
  input  logic [2:0]            coef_addr,
  input  logic [MAN+EXP:0]      coef_data,
  output logic                  out_valid,
  output logic [CHW-1:0]        out_ch,
  output logic [MAN+EXP:0]      y_float,
  output logic                  busy,
  output logic                  ch_err
);

  localparam int W    = float_width(MAN, EXP);
  localparam int CHW1 = CHW + 1;
  localparam logic [CHW:0] NCH_L = CHW1'(NCH);

  state_t         state;
  logic [CHW-1:0] ch;
  logic [W-1:0]   x_float, xf_new;
  logic [W-1:0]   acc, prod, sum;
  logic [W-1:0]   coef_sel, opnd_sel;
  logic [W-1:0]   coef [5];
  logic [W-1:0]   x1, x2, y1, y2;
  logic           accept, commit;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid & in_ready;
  assign commit   = (state == M4);

  int2float #(.MAN(MAN), .EXP(EXP)) u_i2f (.x(x), .f(xf_new));

  // Pick coefficient and operand for the current tap; a-terms are negated by flipping the sign bit.
  always_comb begin
    coef_sel = coef[CB0];
    opnd_sel = x_float;
    unique case (state)
      M1:      begin coef_sel = coef[CB1]; opnd_sel = x1; end
      M2:      begin coef_sel = coef[CB2]; opnd_sel = x2; end
      M3:      begin coef_sel = {~coef[CA1][W-1], coef[CA1][W-2:0]}; opnd_sel = y1; end
      M4:      begin coef_sel = {~coef[CA2][W-1], coef[CA2][W-2:0]}; opnd_sel = y2; end
      default: ;
    endcase
  end

  mult #(.MAN(MAN), .EXP(EXP)) u_mult (.a(coef_sel), .b(opnd_sel), .y(prod));
  soma #(.MAN(MAN), .EXP(EXP)) u_soma (.a(acc), .b(prod), .y(sum));

  iir_hist_mem #(.W(W), .NCH(NCH), .CHW(CHW)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .ch    (ch),
    .we    (commit),
    .x_new (x_float),
    .y_new (sum),
    .x1    (x1),
    .x2    (x2),
    .y1    (y1),
    .y2    (y2)
  );

  // Coefficient bank: writable only while idle so an in-flight sample sees one consistent set.
  always_ff @(posedge clk) begin
    if (rst) begin
      coef[CB0] <= B0;
      coef[CB1] <= B1;
      coef[CB2] <= B2;
      coef[CA1] <= A1;
      coef[CA2] <= A2;
    end else if (coef_we && state == IDLE) begin
      case (coef_addr)
        CB0:     coef[CB0] <= coef_data;
        CB1:     coef[CB1] <= coef_data;
        CB2:     coef[CB2] <= coef_data;
        CA1:     coef[CA1] <= coef_data;
        CA2:     coef[CA2] <= coef_data;
        default: ;
      endcase
    end
  end

  // Sequencer: accept, five multiply-accumulate steps, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ch        <= '0;
      x_float   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      y_float   <= '0;
      ch_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      ch_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if ({1'b0, in_ch} >= NCH_L) begin
              ch_err <= 1'b1;
            end else begin
              ch      <= in_ch;
              x_float <= xf_new;
              state   <= M0;
            end
          end
        end
        M0: begin acc <= prod; state <= M1; end
        M1: begin acc <= sum;  state <= M2; end
        M2: begin acc <= sum;  state <= M3; end
        M3: begin acc <= sum;  state <= M4; end
        M4: begin
          y_float   <= sum;
          out_ch    <= ch;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc with a result scoreboard.
module tb_iir_biquad_mc;

  localparam int MAN = 23;
  localparam int EXP = 8;
  localparam int NCH = 3;
  localparam int CHW = 2;

  localparam logic [31:0] F_0   = 32'h00000000;
  localparam logic [31:0] F_1   = 32'h3F800000;
  localparam logic [31:0] F_2   = 32'h40000000;
  localparam logic [31:0] F_3   = 32'h40400000;
  localparam logic [31:0] F_4   = 32'h40800000;
  localparam logic [31:0] F_5   = 32'h40A00000;
  localparam logic [31:0] F_6   = 32'h40C00000;
  localparam logic [31:0] F_M05 = 32'hBF000000;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [31:0]    y;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [CHW-1:0]        in_ch = '0;
  logic signed [MAN-1:0] x = '0;
  logic                  coef_we = 1'b0;
  logic [2:0]            coef_addr = '0;
  logic [31:0]           coef_data = '0;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic [31:0]           y_float;
  logic                  busy;
  logic                  ch_err;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  iir_biquad_mc #(.MAN(MAN), .EXP(EXP), .NCH(NCH), .CHW(CHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .x         (x),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .y_float   (y_float),
    .busy      (busy),
    .ch_err    (ch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard consumer: every result strobe must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("y_float", y_float, e.y);
          check("out_ch", {30'b0, out_ch}, {30'b0, e.ch});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_coef(input logic [2:0] addr, input logic [31:0] data);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offer one sample (optionally with a same-cycle coefficient write); returns at the T+1 negedge.
  task automatic do_sample(input int c, input int xv, input bit push, input logic [31:0] y_exp,
                           input bit we = 1'b0, input logic [2:0] addr = 3'd0,
                           input logic [31:0] data = 32'd0);
    int n = 0;
    exp_t e;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_ch     = c[CHW-1:0];
    x         = xv[MAN-1:0];
    coef_we   = we;
    coef_addr = addr;
    coef_data = data;
    if (push) begin
      e.ch = c[CHW-1:0];
      e.y  = y_exp;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ch_err", {31'b0, ch_err}, 32'd0);
    check("rst_y_float", y_float, F_0);
    check("rst_out_ch", {30'b0, out_ch}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 1: default coefficients pass x through; check latency and handshake
    do_sample(0, 5, 1'b1, F_5);
    for (int k = 1; k <= 5; k++) begin
      check("in_ready_low_while_busy", {31'b0, in_ready}, 32'd0);
      check("busy_high", {31'b0, busy}, 32'd1);
      check("no_early_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check("out_valid_at_T6", {31'b0, out_valid}, 32'd1);
    check("in_ready_at_T6", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check("out_valid_one_cycle", {31'b0, out_valid}, 32'd0);
    check("y_float_holds", y_float, F_5);
    wait_drain();

    // 2: a1 = -0.5 gives y[n] = x[n] + 0.5*y[n-1]
    set_coef(3'd3, F_M05);
    do_sample(1, 4, 1'b1, F_4); wait_drain();
    do_sample(1, 0, 1'b1, F_2); wait_drain();
    do_sample(1, 0, 1'b1, F_1); wait_drain();

    // 3: channel isolation from clean history
    apply_reset();
    set_coef(3'd3, F_M05);
    do_sample(0, 4, 1'b1, F_4); wait_drain();
    do_sample(1, 0, 1'b1, F_0); wait_drain();
    do_sample(0, 0, 1'b1, F_2); wait_drain();
    do_sample(1, 0, 1'b1, F_0); wait_drain();
    do_sample(0, 0, 1'b1, F_1); wait_drain();
    do_sample(1, 0, 1'b1, F_0); wait_drain();

    // 4: FIR impulse on ch2 with b0=b1=b2=1, a=0
    set_coef(3'd1, F_1);
    set_coef(3'd2, F_1);
    set_coef(3'd3, F_0);
    do_sample(2, 1, 1'b1, F_1); wait_drain();
    do_sample(2, 0, 1'b1, F_1); wait_drain();
    do_sample(2, 0, 1'b1, F_1); wait_drain();
    do_sample(2, 0, 1'b1, F_0); wait_drain();

    // 5: write while busy is dropped; write in idle applies; write with accept is seen
    // ch0 history here: x1=0, x2=0.
    do_sample(0, 3, 1'b1, F_3);
    @(negedge clk);
    set_coef(3'd0, F_2);
    wait_drain();
    do_sample(0, 1, 1'b1, F_4); wait_drain();
    set_coef(3'd0, F_2);
    do_sample(0, 1, 1'b1, F_6); wait_drain();
    do_sample(0, 2, 1'b1, F_4, 1'b1, 3'd0, F_1); wait_drain();

    // 6: reset mid-computation aborts and clears history
    do_sample(0, 7, 1'b0, F_0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (8) @(negedge clk);
    check("abort_y_float_reset", y_float, F_0);
    set_coef(3'd1, F_1);
    do_sample(0, 5, 1'b1, F_5); wait_drain();

    // 6b: out-of-range channel is consumed with an error pulse only
    do_sample(NCH, 9, 1'b0, F_0);
    check("ch_err_pulse", {31'b0, ch_err}, 32'd1);
    check("ch_err_busy", {31'b0, busy}, 32'd0);
    check("ch_err_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    check("ch_err_one_cycle", {31'b0, ch_err}, 32'd0);
    repeat (8) @(negedge clk);
    check("ch_err_no_result", y_float, F_5);

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
